// File: rtl/data_mem_pkg.sv
// Shared IO map offsets and address-region decode type for the data memory with MMIO.
package data_mem_pkg;

  localparam int unsigned OFS_SW     = 0;
  localparam int unsigned OFS_LEDS   = 1;
  localparam int unsigned OFS_CYCLE  = 2;
  localparam int unsigned OFS_STATUS = 3;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_SW,
    RGN_LEDS,
    RGN_CYCLE,
    RGN_STATUS,
    RGN_UNMAPPED
  } region_e;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchroniser for the switch inputs, plus a one-cycle pulse whenever
// the synchronised value differs from its value one cycle earlier.
module sw_sync #(
  parameter int N_SW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_s,
  output logic            sw_chg
);

  logic [N_SW-1:0] meta_q, meta_d;
  logic [N_SW-1:0] sync_q, sync_d;
  logic [N_SW-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = sw;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sw_s   = sync_q;
  assign sw_chg = (sync_q != prev_q);

endmodule

// File: rtl/data_memory_mmio.sv
// Word-addressed data RAM with byte-enable writes and a small MMIO block
// (switches, LEDs, free-running cycle counter, status); reads return one cycle later.
module data_memory_mmio
  import data_mem_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter int                ADDR_W  = 13,
  parameter int                DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_BASE = 13'h100,
  parameter int                N_SW    = 8,
  parameter int                N_LED   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   Addres,
  input  logic                memWr,
  input  logic                memRd,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   datawr,
  input  logic [N_SW-1:0]     sw,
  output logic [DATA_W-1:0]   datard,
  output logic                rd_valid,
  output logic [N_LED-1:0]    leds,
  output logic                err
);

  localparam int                NB      = DATA_W / 8;
  localparam int                RAM_AW  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] datard_q, datard_d;
  logic              rd_valid_q, rd_valid_d;
  logic [N_LED-1:0]  leds_q, leds_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic              chg_q, chg_d;

  logic [N_SW-1:0]   sw_s;
  logic              sw_chg;
  region_e           region;
  logic [ADDR_W-1:0] io_ofs;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en, rd_en, both, ram_we;
  logic [DATA_W-1:0] rdata;

  sw_sync #(.N_SW(N_SW)) u_sw_sync (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .sw_s   (sw_s),
    .sw_chg (sw_chg)
  );

  assign io_ofs  = Addres - IO_BASE;
  assign ram_idx = Addres[RAM_AW-1:0];

  always_comb begin
    region = RGN_UNMAPPED;
    if (Addres < DEPTH_A) begin
      region = RGN_RAM;
    end else if (Addres >= IO_BASE) begin
      case (io_ofs)
        ADDR_W'(OFS_SW):     region = RGN_SW;
        ADDR_W'(OFS_LEDS):   region = RGN_LEDS;
        ADDR_W'(OFS_CYCLE):  region = RGN_CYCLE;
        ADDR_W'(OFS_STATUS): region = RGN_STATUS;
        default:             region = RGN_UNMAPPED;
      endcase
    end
  end

  // A cycle with both strobes performs no access at all; reset discards accesses.
  always_comb begin
    both   = !rst && memWr && memRd;
    wr_en  = !rst && memWr && !memRd;
    rd_en  = !rst && memRd && !memWr;
    ram_we = wr_en && (region == RGN_RAM);

    rdata = '0;
    case (region)
      RGN_RAM:    rdata = mem[ram_idx];
      RGN_SW:     rdata = DATA_W'(sw_s);
      RGN_LEDS:   rdata = DATA_W'(leds_q);
      RGN_CYCLE:  rdata = cycle_q;
      RGN_STATUS: rdata = DATA_W'({chg_q, err_q});
      default:    rdata = '0;
    endcase

    datard_d   = rd_en ? rdata : datard_q;
    rd_valid_d = rd_en;

    leds_d = leds_q;
    if (wr_en && (region == RGN_LEDS) && be[0]) leds_d = datawr[N_LED-1:0];

    cycle_d = cycle_q + DATA_W'(1);
    if (wr_en && (region == RGN_CYCLE)) cycle_d = '0;

    // A new change in the same cycle as a STATUS read keeps the bit set.
    chg_d = sw_chg || (chg_q && !(rd_en && (region == RGN_STATUS)));

    err_d = err_q || both
          || (wr_en && (region inside {RGN_SW, RGN_STATUS, RGN_UNMAPPED}))
          || (rd_en && (region == RGN_UNMAPPED));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      datard_q   <= '0;
      rd_valid_q <= 1'b0;
      leds_q     <= '0;
      err_q      <= 1'b0;
      cycle_q    <= '0;
      chg_q      <= 1'b0;
    end else begin
      datard_q   <= datard_d;
      rd_valid_q <= rd_valid_d;
      leds_q     <= leds_d;
      err_q      <= err_d;
      cycle_q    <= cycle_d;
      chg_q      <= chg_d;
    end
  end

  // RAM is deliberately not reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= datawr[8*i +: 8];
      end
    end
  end

  assign datard   = datard_q;
  assign rd_valid = rd_valid_q;
  assign leds     = leds_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed table-driven bench for data_memory_mmio plus hand sequences for reset and counter timing.
module tb_data_memory_mmio;

  localparam logic [12:0] IOB = 13'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] Addres;
  logic        memWr, memRd;
  logic [7:0]  be;
  logic [63:0] datawr;
  logic [7:0]  sw;
  logic [63:0] datard;
  logic        rd_valid;
  logic [7:0]  leds;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_memory_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .Addres   (Addres),
    .memWr    (memWr),
    .memRd    (memRd),
    .be       (be),
    .datawr   (datawr),
    .sw       (sw),
    .datard   (datard),
    .rd_valid (rd_valid),
    .leds     (leds),
    .err      (err)
  );

  typedef struct {
    string       name;
    bit          rst, wr, rd;
    logic [12:0] addr;
    logic [7:0]  be;
    logic [63:0] wdat;
    logic [7:0]  sw;
    bit          exp_rv;
    bit          chk_dat;
    logic [63:0] exp_dat;
    bit          exp_err;
    logic [7:0]  exp_leds;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, bit r, bit w, bit rd, logic [12:0] a, logic [7:0] b,
                              logic [63:0] wd, logic [7:0] s, bit rv, bit cd, logic [63:0] d,
                              bit e, logic [7:0] l);
    vec_t v;
    v.name = name; v.rst = r; v.wr = w; v.rd = rd; v.addr = a; v.be = b; v.wdat = wd;
    v.sw = s; v.exp_rv = rv; v.chk_dat = cd; v.exp_dat = d; v.exp_err = e; v.exp_leds = l;
    return v;
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit r, bit w, bit rd, logic [12:0] a, logic [7:0] b, logic [63:0] wd, logic [7:0] s);
    @(negedge clk);
    rst = r; memWr = w; memRd = rd; Addres = a; be = b; datawr = wd; sw = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; memWr = 1'b0; memRd = 1'b0; Addres = '0; be = '0; datawr = '0; sw = '0;

    // name          rst wr rd addr     be     wdat                    sw    rv chk dat                      err leds
    vq.push_back(mk("wr0_8",      0,1,0, 13'd0,   8'hFF, 64'd8,                  8'd0, 0,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("rd0_8",      0,0,1, 13'd0,   8'h00, 64'd0,                  8'd0, 1,1, 64'd8,                    0, 8'd0));
    vq.push_back(mk("wr5_ones",   0,1,0, 13'd5,   8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 0,1, 64'd8,                    0, 8'd0));
    vq.push_back(mk("wr5_be01",   0,1,0, 13'd5,   8'h01, 64'h0,                  8'd0, 0,1, 64'd8,                    0, 8'd0));
    vq.push_back(mk("rd5_merge",  0,0,1, 13'd5,   8'h00, 64'h0,                  8'd0, 1,1, 64'hFFFF_FFFF_FFFF_FF00,  0, 8'd0));
    vq.push_back(mk("sw9_hold1",  0,0,0, 13'd0,   8'h00, 64'h0,                  8'd9, 0,1, 64'hFFFF_FFFF_FFFF_FF00,  0, 8'd0));
    vq.push_back(mk("sw9_hold2",  0,0,0, 13'd0,   8'h00, 64'h0,                  8'd9, 0,0, 64'h0,                    0, 8'd0));
    vq.push_back(mk("sw9_hold3",  0,0,0, 13'd0,   8'h00, 64'h0,                  8'd9, 0,0, 64'h0,                    0, 8'd0));
    vq.push_back(mk("rd_sw",      0,0,1, IOB,     8'h00, 64'h0,                  8'd9, 1,1, 64'd9,                    0, 8'd0));
    vq.push_back(mk("rd_status1", 0,0,1, IOB+3,   8'h00, 64'h0,                  8'd9, 1,1, 64'd2,                    0, 8'd0));
    vq.push_back(mk("rd_status2", 0,0,1, IOB+3,   8'h00, 64'h0,                  8'd9, 1,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("wr_leds7",   0,1,0, IOB+1,   8'h01, 64'd7,                  8'd9, 0,1, 64'd0,                    0, 8'd7));
    vq.push_back(mk("wr_leds_be0",0,1,0, IOB+1,   8'hFE, 64'd3,                  8'd9, 0,0, 64'd0,                    0, 8'd7));
    vq.push_back(mk("rd_leds",    0,0,1, IOB+1,   8'h00, 64'h0,                  8'd9, 1,1, 64'd7,                    0, 8'd7));
    vq.push_back(mk("rst_wr_drop",1,1,0, 13'd0,   8'hFF, 64'd99,                 8'd0, 0,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("rd0_kept",   0,0,1, 13'd0,   8'h00, 64'h0,                  8'd0, 1,1, 64'd8,                    0, 8'd0));
    vq.push_back(mk("both_strb",  0,1,1, 13'd0,   8'hFF, 64'd3,                  8'd0, 0,1, 64'd8,                    1, 8'd0));
    vq.push_back(mk("rd0_after",  0,0,1, 13'd0,   8'h00, 64'h0,                  8'd0, 1,1, 64'd8,                    1, 8'd0));
    vq.push_back(mk("rd_st_err",  0,0,1, IOB+3,   8'h00, 64'h0,                  8'd0, 1,1, 64'd1,                    1, 8'd0));
    vq.push_back(mk("rst2",       1,0,0, 13'd0,   8'h00, 64'h0,                  8'd0, 0,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("rd0_again",  0,0,1, 13'd0,   8'h00, 64'h0,                  8'd0, 1,1, 64'd8,                    0, 8'd0));
    vq.push_back(mk("rd_unmap",   0,0,1, IOB+9,   8'h00, 64'h0,                  8'd0, 1,1, 64'd0,                    1, 8'd0));
    vq.push_back(mk("rst3",       1,0,0, 13'd0,   8'h00, 64'h0,                  8'd0, 0,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("wr_cycle",   0,1,0, IOB+2,   8'hFF, 64'd0,                  8'd0, 0,0, 64'd0,                    0, 8'd0));
    vq.push_back(mk("cyc_idle",   0,0,0, 13'd0,   8'h00, 64'h0,                  8'd0, 0,0, 64'd0,                    0, 8'd0));
    vq.push_back(mk("rd_cycle",   0,0,1, IOB+2,   8'h00, 64'h0,                  8'd0, 1,1, 64'd1,                    0, 8'd0));
    vq.push_back(mk("rst4",       1,0,0, 13'd0,   8'h00, 64'h0,                  8'd0, 0,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("wr_sw_err",  0,1,0, IOB,     8'hFF, 64'd5,                  8'd0, 0,1, 64'd0,                    1, 8'd0));
    vq.push_back(mk("rst5",       1,0,0, 13'd0,   8'h00, 64'h0,                  8'd0, 0,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("wr_st_err",  0,1,0, IOB+3,   8'hFF, 64'd5,                  8'd0, 0,0, 64'd0,                    1, 8'd0));
    vq.push_back(mk("rst6",       1,0,0, 13'd0,   8'h00, 64'h0,                  8'd0, 0,1, 64'd0,                    0, 8'd0));
    vq.push_back(mk("wr_ff",      0,1,0, 13'hFF,  8'hFF, 64'hAB,                 8'd0, 0,0, 64'd0,                    0, 8'd0));
    vq.push_back(mk("rd_ff_b2b",  0,0,1, 13'hFF,  8'h00, 64'h0,                  8'd0, 1,1, 64'hAB,                   0, 8'd0));
    vq.push_back(mk("rd0_b2b",    0,0,1, 13'd0,   8'h00, 64'h0,                  8'd0, 1,1, 64'd8,                    0, 8'd0));
    vq.push_back(mk("rd_top",     0,0,1, 13'h1FFF,8'h00, 64'h0,                  8'd0, 1,1, 64'd0,                    1, 8'd0));

    // Reset state after two reset edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset_datard", datard, 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_leds", 64'(leds), 64'd0);
    check("reset_err", 64'(err), 64'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].wr, vq[i].rd, vq[i].addr, vq[i].be, vq[i].wdat, vq[i].sw);
      check({vq[i].name, "_rv"}, 64'(rd_valid), 64'(vq[i].exp_rv));
      check({vq[i].name, "_err"}, 64'(err), 64'(vq[i].exp_err));
      check({vq[i].name, "_leds"}, 64'(leds), 64'(vq[i].exp_leds));
      if (vq[i].chk_dat) check({vq[i].name, "_dat"}, datard, vq[i].exp_dat);
    end

    // Free-running counter: reset, five idle cycles, then the read samples 5.
    drive(1, 0, 0, 13'd0, 8'h00, 64'h0, 8'd0);
    repeat (5) drive(0, 0, 0, 13'd0, 8'h00, 64'h0, 8'd0);
    drive(0, 0, 1, IOB+2, 8'h00, 64'h0, 8'd0);
    check("cycle_free_run", datard, 64'd5);
    check("cycle_free_rv", 64'(rd_valid), 64'd1);

    // rd_valid drops after one cycle while datard holds.
    drive(0, 0, 0, 13'd0, 8'h00, 64'h0, 8'd0);
    check("hold_rv_low", 64'(rd_valid), 64'd0);
    check("hold_datard", datard, 64'd5);

    // Read of the word written in the immediately preceding cycle.
    drive(0, 1, 0, 13'd3, 8'hF0, 64'h1234_5678_9ABC_DEF0, 8'd0);
    drive(0, 1, 0, 13'd3, 8'h0F, 64'h1111_2222_3333_4444, 8'd0);
    drive(0, 0, 1, 13'd3, 8'h00, 64'h0, 8'd0);
    check("rd_after_wr", datard, 64'h1234_5678_3333_4444);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 13, meaning word-address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning RAM words (power of two, DEPTH <= IO_BASE).
REQ-004 SHALL have parameter IO_BASE, default 13'h100, meaning first memory-mapped IO word address.
REQ-005 SHALL have parameter N_SW, default 8, meaning switch input width; N_LED, default 8, meaning LED output width.
REQ-006 SHALL have port clk  input  1  the single clock; all logic is rising-edge clocked.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port Addres  input  ADDR_W  word address.
REQ-009 SHALL have port memWr  input  1  write strobe, one word per asserted cycle.
REQ-010 SHALL have port memRd  input  1  read strobe.
REQ-011 SHALL have port be  input  DATA_W/8  byte enables for writes.
REQ-012 SHALL have port datawr  input  DATA_W  write data.
REQ-013 SHALL have port sw  input  N_SW  asynchronous switch inputs.
REQ-014 SHALL have port datard  output  DATA_W  read data, registered.
REQ-015 SHALL have port rd_valid  output  1  datard holds the result of the previous cycle's read.
REQ-016 SHALL have port leds  output  N_LED  LED register.
REQ-017 SHALL have port err  output  1  sticky access-error flag.

Function
REQ-018 SHALL decode: Addres < DEPTH -> RAM; IO_BASE+0 SW (RO); +1 LEDS (RW); +2 CYCLE counter (RO, write clears); +3 STATUS (RO: bit0 err, bit1 sw-changed); anything else -> unmapped.
REQ-019 SHALL write RAM bytes only where be[i]=1; other bytes keep their value.
REQ-020 SHALL update leds from datawr[N_LED-1:0] on a LEDS write when be[0]=1; the new value is visible on leds the next cycle.
REQ-021 SHALL return read data exactly 1 cycle after memRd, with rd_valid high for exactly that cycle; datard holds its last value while rd_valid is low.
REQ-022 SHALL zero-extend SW, LEDS and STATUS reads to DATA_W.
REQ-023 SHALL pass sw through a 2-flop synchroniser; SW reads return the synchronised value (2-cycle input latency).
REQ-024 SHALL set STATUS bit1 when the synchronised sw differs from its previous-cycle value; a STATUS read clears bit1 unless a change occurs in the same cycle (set wins).
REQ-025 SHALL increment CYCLE by 1 every cycle, wrap from all-ones to 0; a CYCLE write loads 0 (the increment resumes the next cycle).
REQ-026 SHALL, on memWr and memRd in the same cycle, perform neither access, set err and leave rd_valid low.
REQ-027 SHALL, on an access to an unmapped address, or a write to SW or STATUS, set err, ignore the write, and for reads return 0 with rd_valid high.
REQ-028 SHALL keep err set until reset; RAM reads of never-written words return undefined data (no RAM initialisation).
REQ-029 SHALL support back-to-back reads every cycle at full throughput and a read of the address written in the previous cycle returns the new data.

Reset
REQ-030 SHALL, with rst high at a rising edge, clear datard, rd_valid, leds, err, CYCLE, STATUS and the synchroniser flops to 0.
REQ-031 SHALL leave RAM contents unchanged by reset; an access presented during a reset cycle is discarded.

Structure
REQ-032 SHALL place the IO offsets (SW, LEDS, CYCLE, STATUS) and the region-decode enum in shared package data_mem_pkg.
REQ-033 SHALL implement the switch synchroniser plus change detector as sub-module sw_sync; RAM and decode stay in data_memory_mmio.

Verification
REQ-034 SHALL cover: write 64'd8 be=8'hFF to addr 0, read addr 0 -> datard=8, rd_valid high 1 cycle later.
REQ-035 SHALL cover: write 64'hFFFF_FFFF_FFFF_FFFF to addr 5, then 64'h0 with be=8'h01, read -> 64'hFFFF_FFFF_FFFF_FF00.
REQ-036 SHALL cover: sw=9 held 3 cycles, read IO_BASE -> datard=9 and STATUS read -> 2'b10, second STATUS read -> 0.
REQ-037 SHALL cover: write 7 to IO_BASE+1 -> leds=8'h07 next cycle; rst pulse -> leds=0, RAM addr 0 still 8.
REQ-038 SHALL cover: memWr=memRd=1 at addr 0 with datawr=3 -> addr 0 still 8, err=1, rd_valid=0.
REQ-039 SHALL cover: read IO_BASE+9 -> datard=0, rd_valid=1, err=1; write 0 to IO_BASE+2 -> CYCLE read two cycles later returns 1.
